// File: rtl/add_share_arb_pkg.sv
// add_share_arb_pkg
// Shared constants and types for the shared-adder arbiter.
//   ADD_OUT_WIDTH   : adder operand/result width used across the TNN datapath
//   ADD_ARB_NUM_REQ : default number of requesters sharing one adder
//   ADD_ARB_IDX_W   : width of a requester ID
//   arb_state_e     : arbiter FSM encoding (IDLE = free arbitration, LOCK = burst owner holds adder)
//   rr_wrap_inc     : increment a requester index with wrap-around
package add_share_arb_pkg;

    localparam int ADD_OUT_WIDTH   = 16;
    localparam int ADD_ARB_NUM_REQ = 4;
    localparam int ADD_ARB_IDX_W   = $clog2(ADD_ARB_NUM_REQ);

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    // Next round-robin start position after requester 'id' was served.
    function automatic int rr_wrap_inc(input int id, input int n);
        return (id + 1 >= n) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/add_share_arb_rr_grant.sv
// rr_grant
// Combinational round-robin grant: picks the first asserted request at or after
// ptr_i, scanning upward and wrapping from NUM_REQ-1 to 0.
//   req_i  : request vector
//   ptr_i  : scan start position (must be < NUM_REQ)
//   gnt_o  : one-hot grant (all zero when nothing requests)
//   id_o   : encoded ID of the granted requester (0 when none)
//   any_o  : a grant was issued
module rr_grant #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   id_o,
    output logic               any_o
);

    always_comb begin
        int idx;
        idx   = 0;
        gnt_o = '0;
        id_o  = '0;
        any_o = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_o && req_i[idx]) begin
                any_o      = 1'b1;
                gnt_o[idx] = 1'b1;
                id_o       = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/add_unit.sv
// add_unit
// Registered two-operand adder, one cycle of latency. The carry out is dropped,
// so the result wraps modulo 2^data_in_width.
//   clk    : clock
//   rst_n  : asynchronous active-low reset (clears the sum register)
//   a_i    : operand A
//   b_i    : operand B
//   sum_o  : registered (a_i + b_i)
module add_unit #(
    parameter int data_in_width = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [data_in_width-1:0] a_i,
    input  logic [data_in_width-1:0] b_i,
    output logic [data_in_width-1:0] sum_o
);

    logic [data_in_width-1:0] sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= a_i + b_i;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/add_share_arb.sv
// add_share_arb
// Shares one registered adder among NUM_REQ requesters. Round-robin arbitration
// with optional burst locking; each operation is tagged with its requester ID and
// the result is strobed back one-hot two edges after the handshake.
//   clk          : clock
//   rst_n        : asynchronous active-low reset; discards in-flight operations
//   req_valid_i  : per-requester operation request
//   req_last_i   : final operation of a burst (ignored when LOCK_EN=0)
//   req_a_i      : packed operand A, requester i at [i*DATA_W +: DATA_W]
//   req_b_i      : packed operand B, same packing
//   req_ready_o  : one-hot grant; handshake = req_valid_i[i] & req_ready_o[i]
//   rsp_valid_o  : one-hot single-cycle result strobe
//   rsp_data_o   : result, broadcast to all requesters
//   rsp_id_o     : owner of rsp_data_o
//   locked_o     : a burst lock is held
//   busy_o       : an operation is in flight or a lock is held
module add_share_arb
    import add_share_arb_pkg::*;
#(
    parameter int NUM_REQ = ADD_ARB_NUM_REQ,
    parameter int DATA_W  = ADD_OUT_WIDTH,
    parameter int IDX_W   = $clog2(NUM_REQ),
    parameter bit LOCK_EN = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ-1:0]        req_last_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]         rsp_data_o,
    output logic [IDX_W-1:0]          rsp_id_o,
    output logic                      locked_o,
    output logic                      busy_o
);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] req_mask;

    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_id;
    logic               hs;

    logic [DATA_W-1:0]  sel_a, sel_b;
    logic [DATA_W-1:0]  op_a_q, op_b_q;
    logic               s1_valid_q, s2_valid_q;
    logic [IDX_W-1:0]   s1_tag_q, s2_tag_q;
    logic [DATA_W-1:0]  sum;

    // While locked only the owner may compete, so an absent owner blocks everyone.
    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_grant (
        .req_i   (req_valid_i & req_mask),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt),
        .id_o    (gnt_id),
        .any_o   (hs)
    );

    assign req_ready_o = gnt;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            ARB_IDLE: begin
                if (LOCK_EN && hs && !req_last_i[gnt_id]) begin
                    state_d = ARB_LOCK;
                    owner_d = gnt_id;
                end
            end
            ARB_LOCK: begin
                if (hs && req_last_i[gnt_id]) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        locked_o = 1'b0;
        req_mask = '1;
        if (state_q == ARB_LOCK) begin
            locked_o = 1'b1;
            req_mask = NUM_REQ'(1) << owner_q;
        end
    end

    // Pointer only advances on handshakes that leave the arbiter free, so the
    // requester after a burst owner gets first chance once the burst ends.
    always_comb begin
        ptr_d = ptr_q;
        if (hs && state_d == ARB_IDLE) begin
            ptr_d = IDX_W'(rr_wrap_inc(int'(gnt_id), NUM_REQ));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // ---------------- Pipeline ----------------
    assign sel_a = req_a_i[int'(gnt_id)*DATA_W +: DATA_W];
    assign sel_b = req_b_i[int'(gnt_id)*DATA_W +: DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q     <= '0;
            op_b_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_tag_q   <= '0;
        end else begin
            if (hs) begin
                op_a_q   <= sel_a;
                op_b_q   <= sel_b;
                s1_tag_q <= gnt_id;
            end
            s1_valid_q <= hs;
            s2_valid_q <= s1_valid_q;
            s2_tag_q   <= s1_tag_q;
        end
    end

    add_unit #(
        .data_in_width (DATA_W)
    ) u_add_unit (
        .clk   (clk),
        .rst_n (rst_n),
        .a_i   (op_a_q),
        .b_i   (op_b_q),
        .sum_o (sum)
    );

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
            assign rsp_valid_o[gi] = s2_valid_q && (s2_tag_q == IDX_W'(gi));
        end
    endgenerate

    assign rsp_data_o = sum;
    assign rsp_id_o   = s2_tag_q;
    assign busy_o     = s1_valid_q | s2_valid_q | locked_o;

endmodule

// File: doc/add_share_arb.md
Name: add_share_arb

Overview:
- Shares a single add_unit instance, a registered two-operand adder with one cycle of latency, among NUM_REQ requesters in the TNN datapath, e.g. the partial-sum accumulators of parallel neuron lanes.
- Arbitrates round-robin and supports locked bursts, so one requester can keep the adder for a chain of operations.
- Registers the operands, tags each operation with its requester ID, and returns each result one-hot to the originating requester.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_W, `ADD_OUT_WIDTH, operand and result width.
- IDX_W, $clog2(NUM_REQ), requester ID width.
- LOCK_EN, 1, when 1 honours req_last burst locking; when 0 every grant is single-shot.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_last  in  NUM_REQ  marks the final operation of a burst; ignored when LOCK_EN=0.
- req_a  in  NUM_REQ*DATA_W  packed operand A; requester i occupies bits [i*DATA_W +: DATA_W].
- req_b  in  NUM_REQ*DATA_W  packed operand B, same packing.
- req_ready  out  NUM_REQ  one-hot grant; a handshake is req_valid[i] & req_ready[i].
- rsp_valid  out  NUM_REQ  one-hot result strobe, one cycle wide.
- rsp_data  out  DATA_W  result, broadcast to all requesters.
- rsp_id  out  IDX_W  ID of the requester owning rsp_data.
- locked  out  1  a burst lock is active.
- busy  out  1  any operation is in flight or a lock is held.

Behaviour:
- Reset (asynchronous, rst_n low):
  - rsp_valid=0, rsp_id=0, rsp_data=0, locked=0, busy=0.
  - Round-robin pointer = 0, FSM = IDLE, both pipeline valid bits cleared.
  - In-flight operations are discarded and never produce rsp_valid.
- Arbitration, combinational from req_valid, pointer and FSM state:
  - IDLE: grant the first valid requester at or after the pointer, scanning upward and wrapping from NUM_REQ-1 to 0. req_ready is asserted only for that requester.
  - If no requester is valid, req_ready=0.
  - req_ready never asserts for a requester whose req_valid is low.
- FSM states IDLE and LOCK:
  - IDLE -> LOCK: on a handshake with req_last=0 while LOCK_EN=1; the owner ID is stored.
  - LOCK: only the owner can be granted. If the owner drops req_valid, no other requester is granted and the lock persists.
  - LOCK -> IDLE: on an owner handshake with req_last=1.
  - LOCK_EN=0: the FSM stays in IDLE.
- Pointer update: after any handshake that leaves the FSM in IDLE, pointer = granted ID + 1, modulo NUM_REQ. The pointer does not move while in LOCK.
- Pipeline:
  - Stage 1, on the handshake edge: the granted operands are registered into op_a/op_b, which drive add_unit. The tag and the s1 valid bit are also registered.
  - Stage 2: add_unit registers the sum. The tag and valid bit are delayed alongside it.
  - A handshake at edge T gives rsp_valid at edge T+2, with rsp_data = (a+b) mod 2^DATA_W. The adder carry is dropped.
  - Throughput is one operation per cycle with back-to-back handshakes.
  - rsp_valid[i] = s2_valid & (s2_tag==i). rsp_id and rsp_data are meaningful only while rsp_valid is asserted.
  - There is no response backpressure; a requester must accept its result in the cycle of the strobe.
- busy = s1_valid | s2_valid | (state==LOCK).
- Operands are sampled only on handshake. Changes to req_a/req_b without a handshake have no effect.

Decomposition:
- Shared package or header network_params.vh:
  - ADD_OUT_WIDTH, already defined there.
  - New constants ADD_ARB_NUM_REQ and ADD_ARB_IDX_W.
  - FSM state encoding: ARB_IDLE=1'b0, ARB_LOCK=1'b1.
- Instantiates add_unit with data_in_width=DATA_W.
- The round-robin grant logic is a natural sub-module, rr_grant. Its inputs are the request vector and pointer; its outputs are the one-hot grant and the encoded ID.

Test Plan:
- Single request: requester 2 presents a=5, b=7, valid for one cycle at edge T. Required: rsp_valid=4'b0100, rsp_id=2, rsp_data=12 at edge T+2.
- All four requesters valid continuously, LOCK_EN=1, req_last=1 everywhere, pointer 0. Required: grants in order 0,1,2,3,0; results in the same order, one per cycle, two cycles behind each grant.
- Burst lock:
  - Requester 1 issues three operations with req_last=0,0,1 while requester 3 is valid throughout.
  - Requester 1 drops valid for two cycles mid-burst.
  - Required: requester 3 is not granted until the cycle after requester 1's last handshake; locked=1 during the gap.
- Wrap and overflow, DATA_W=16: a=16'hFFFF, b=16'h0002. Required: rsp_data=16'h0001. Also, with pointer at 3 and only requester 0 valid, requester 0 is granted.
- Reset mid-operation: assert rst_n low one cycle after a handshake. Required: no rsp_valid ever appears for that operation, locked=0, busy=0; after release the first grant goes to requester 0.
- LOCK_EN=0 with req_last=0 on every operation. Required: the FSM never enters LOCK and requesters rotate fairly.
